// File: rtl/onehot_scan_encoder_if.sv
// Handshake bundle between the scan encoder and its producer/consumer.
// The slave side is the encoder; the master side starts scans and accepts indices.
interface onehot_scan_encoder_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
);
    logic             start;
    logic [WIDTH-1:0] vec_in;
    logic             out_ready;
    logic             idx_valid;
    logic [IDX_W-1:0] idx_out;
    logic             busy;
    logic             done;
    logic [IDX_W:0]   count;

    modport master (
        output start, vec_in, out_ready,
        input  idx_valid, idx_out, busy, done, count
    );

    modport slave (
        input  start, vec_in, out_ready,
        output idx_valid, idx_out, busy, done, count
    );
endinterface

// File: rtl/onehot_scan_encoder.sv
// Sequential 16-to-4 encoder: captures a vector and emits the index of each set
// bit, lowest first, one per valid/ready handshake, then pulses done.
module onehot_scan_encoder #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    onehot_scan_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shadow_r;
    logic [WIDTH-1:0] shadow_s;
    logic [IDX_W:0]   count_r;
    logic [IDX_W:0]   count_s;
    logic             valid_s;
    logic [IDX_W-1:0] lowest_s;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[IDX_W-1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign valid_s  = (state_r == SCAN) && (shadow_r != {WIDTH{1'b0}});
    assign lowest_s = lowest_set(shadow_r);

    // Outputs decode straight from registered state so reset clears them at once.
    assign bus.idx_valid = valid_s;
    assign bus.idx_out   = valid_s ? lowest_s : {IDX_W{1'b0}};
    assign bus.busy      = (state_r == SCAN) || (state_r == DONE);
    assign bus.done      = (state_r == DONE);
    assign bus.count     = count_r;

    // Next-state logic: capture on start, strip one bit per accept, exit when empty.
    always_comb begin
        state_s  = state_r;
        shadow_s = shadow_r;
        count_s  = count_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    shadow_s = bus.vec_in;
                    count_s  = {(IDX_W+1){1'b0}};
                    state_s  = SCAN;
                end else begin
                    state_s  = IDLE;
                end
            end
            SCAN: begin
                if (shadow_r == {WIDTH{1'b0}}) begin
                    state_s = DONE;
                end else if (bus.out_ready) begin
                    // x & (x-1) clears exactly the lowest set bit, i.e. the one on idx_out.
                    shadow_s = shadow_r & (shadow_r - {{(WIDTH-1){1'b0}}, 1'b1});
                    count_s  = count_r + {{IDX_W{1'b0}}, 1'b1};
                end else begin
                    state_s = SCAN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, shadow vector and accept counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            shadow_r <= {WIDTH{1'b0}};
            count_r  <= {(IDX_W+1){1'b0}};
        end else begin
            state_r  <= state_s;
            shadow_r <= shadow_s;
            count_r  <= count_s;
        end
    end

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Directed bench for onehot_scan_encoder: hand-computed vectors checked cycle by cycle.
module tb_onehot_scan_encoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    onehot_scan_encoder_if #(.WIDTH(16), .IDX_W(4)) bus ();

    onehot_scan_encoder #(.WIDTH(16), .IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input logic [15:0] vec);
        bus.start  = 1'b1;
        bus.vec_in = vec;
        step();
        bus.start  = 1'b0;
    endtask

    task automatic check_idle(input string tag, input logic [4:0] cnt);
        check({tag, ".valid"}, bus.idx_valid, 1'b0);
        check({tag, ".idx"},   bus.idx_out,   4'd0);
        check({tag, ".busy"},  bus.busy,      1'b0);
        check({tag, ".done"},  bus.done,      1'b0);
        check({tag, ".count"}, bus.count,     cnt);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.vec_in    = 16'h0000;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check_idle("reset", 5'd0);

        // Async reset mid-scan after two accepts
        start_scan(16'h00F0);
        check("t1.idx0", bus.idx_out, 4'd4);
        step();
        check("t1.idx1", bus.idx_out, 4'd5);
        step();
        check("t1.idx2", bus.idx_out, 4'd6);
        check("t1.cnt2", bus.count, 5'd2);
        #2 rst = 1'b1;
        #1;
        check_idle("t1.rst", 5'd0);
        #1 rst = 1'b0;
        start_scan(16'h0001);
        check("t1.new.valid", bus.idx_valid, 1'b1);
        check("t1.new.idx", bus.idx_out, 4'd0);
        step();
        check("t1.new.cnt", bus.count, 5'd1);
        step();
        check("t1.new.done", bus.done, 1'b1);
        step();
        check_idle("t1.end", 5'd1);

        // XOR of decoded 4 and 7
        start_scan(16'h0090);
        check("t2.valid0", bus.idx_valid, 1'b1);
        check("t2.idx0", bus.idx_out, 4'd4);
        check("t2.busy0", bus.busy, 1'b1);
        step();
        check("t2.idx1", bus.idx_out, 4'd7);
        check("t2.cnt1", bus.count, 5'd1);
        step();
        check("t2.valid2", bus.idx_valid, 1'b0);
        check("t2.done2", bus.done, 1'b0);
        check("t2.busy2", bus.busy, 1'b1);
        step();
        check("t2.done3", bus.done, 1'b1);
        step();
        check_idle("t2.end", 5'd2);

        // Empty vector
        start_scan(16'h0000);
        check("t3.valid0", bus.idx_valid, 1'b0);
        check("t3.busy0", bus.busy, 1'b1);
        check("t3.done0", bus.done, 1'b0);
        step();
        check("t3.valid1", bus.idx_valid, 1'b0);
        check("t3.busy1", bus.busy, 1'b1);
        check("t3.done1", bus.done, 1'b1);
        step();
        check_idle("t3.end", 5'd0);

        // All ones: every index in order, count reaches 16
        start_scan(16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t4.valid%0d", i), bus.idx_valid, 1'b1);
            check($sformatf("t4.idx%0d", i), bus.idx_out, i);
            check($sformatf("t4.done%0d", i), bus.done, 1'b0);
            step();
        end
        check("t4.valid_end", bus.idx_valid, 1'b0);
        check("t4.cnt", bus.count, 5'b10000);
        step();
        check("t4.done", bus.done, 1'b1);
        step();
        check_idle("t4.end", 5'd16);

        // Backpressure: index 0 held for three stalled cycles
        bus.out_ready = 1'b0;
        start_scan(16'h8001);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t5.hold_valid%0d", i), bus.idx_valid, 1'b1);
            check($sformatf("t5.hold_idx%0d", i), bus.idx_out, 4'd0);
            check($sformatf("t5.hold_cnt%0d", i), bus.count, 5'd0);
            step();
        end
        bus.out_ready = 1'b1;
        check("t5.idx0", bus.idx_out, 4'd0);
        step();
        check("t5.idx1", bus.idx_out, 4'd15);
        check("t5.cnt1", bus.count, 5'd1);
        step();
        check("t5.valid_end", bus.idx_valid, 1'b0);
        check("t5.cnt", bus.count, 5'd2);
        step();
        check("t5.done", bus.done, 1'b1);
        step();
        check_idle("t5.end", 5'd2);

        // Start while busy is ignored; start during done waits for IDLE
        bus.out_ready = 1'b0;
        start_scan(16'h0100);
        check("t6.idx0", bus.idx_out, 4'd8);
        start_scan(16'h0002);
        check("t6.idx_kept", bus.idx_out, 4'd8);
        check("t6.cnt_kept", bus.count, 5'd0);
        bus.out_ready = 1'b1;
        step();
        check("t6.valid_end", bus.idx_valid, 1'b0);
        check("t6.cnt", bus.count, 5'd1);
        step();
        check("t6.done", bus.done, 1'b1);
        bus.start  = 1'b1;
        bus.vec_in = 16'h0004;
        step();
        check("t6.start_at_done.busy", bus.busy, 1'b0);
        check("t6.start_at_done.cnt", bus.count, 5'd1);
        step();
        bus.start = 1'b0;
        check("t6.restart.valid", bus.idx_valid, 1'b1);
        check("t6.restart.idx", bus.idx_out, 4'd2);
        check("t6.restart.cnt", bus.count, 5'd0);
        step();
        check("t6.restart.cnt1", bus.count, 5'd1);
        step();
        check("t6.restart.done", bus.done, 1'b1);
        step();
        check_idle("t6.end", 5'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
